// File: rtl/ctrl_pila_pkg.sv
// ctrl_pila_pkg: shared constants for the return-address stack controller.
// Holds the FSM state encoding and the default address/depth/pointer widths
// that the PC register and PC adder also use.
package ctrl_pila_pkg;

  localparam int PKG_AW    = 10;
  localparam int PKG_DEPTH = 8;
  localparam int PKG_PW    = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ERR  = 1'b1;

endpackage

// File: rtl/ctrl_pila_mem.sv
// mem_pila: DEPTH x AW return-address storage.
// One synchronous write port and one combinational read port (regfile style).
// Contents are deliberately not reset.
module mem_pila
  import ctrl_pila_pkg::*;
#(
  parameter int AW    = PKG_AW,
  parameter int DEPTH = PKG_DEPTH,
  parameter int PW    = PKG_PW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [AW-1:0] rdata
);

  logic [AW-1:0] mem_r [DEPTH];

  // Write the addressed entry on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/ctrl_pila.sv
// ctrl_pila: clocked return-address stack controller.
// Pushes on call, pops on ret, handles tail calls (call+ret together),
// and freezes in ERR on overflow/underflow until clr_err.
// Optional macro CTRL_PILA_WRAP_EN: a call when full overwrites the oldest
// entry instead of freezing (ovf still set, FSM stays IDLE).
module ctrl_pila
  import ctrl_pila_pkg::*;
#(
  parameter int AW    = PKG_AW,
  parameter int DEPTH = PKG_DEPTH,
  parameter int PW    = PKG_PW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] pc_in,
  input  logic          clr_err,
  output logic [AW-1:0] ret_addr,
  output logic          ret_valid,
  output logic [PW:0]   depth,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf
);

  logic [0:0]    state_r, state_nxt_s;
  logic [PW-1:0] sp_r, sp_nxt_s;
  logic [PW:0]   depth_r, depth_nxt_s;
  logic [AW-1:0] ret_addr_r, ret_addr_nxt_s;
  logic          ret_valid_r, ret_valid_nxt_s;
  logic          ovf_r, ovf_nxt_s;
  logic          unf_r, unf_nxt_s;

  logic          full_s, empty_s;
  logic [PW-1:0] sp_p1_s, sp_m1_s;
  logic          we_s;
  logic [PW-1:0] waddr_s;
  logic [AW-1:0] rdata_s;

  assign full_s  = (depth_r == (PW+1)'(DEPTH));
  assign empty_s = (depth_r == (PW+1)'(0));
  // Pointer arithmetic wraps naturally on PW bits (modulo DEPTH).
  assign sp_p1_s = sp_r + PW'(1);
  assign sp_m1_s = sp_r - PW'(1);

  // Stack storage; writes are suppressed while reset is held.
  mem_pila #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (we_s & reset),
    .waddr (waddr_s),
    .wdata (pc_in),
    .raddr (sp_m1_s),
    .rdata (rdata_s)
  );

  // Next-state decode for FSM, pointer, depth, flags and output register.
  always_comb begin
    state_nxt_s     = state_r;
    sp_nxt_s        = sp_r;
    depth_nxt_s     = depth_r;
    ret_addr_nxt_s  = ret_addr_r;
    ret_valid_nxt_s = 1'b0;
    ovf_nxt_s       = ovf_r;
    unf_nxt_s       = unf_r;
    we_s            = 1'b0;
    waddr_s         = sp_r;
    if (clr_err) begin
      // Clearing wins over any command in the same cycle; sp/depth kept.
      ovf_nxt_s   = 1'b0;
      unf_nxt_s   = 1'b0;
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ret && empty_s) begin
            // Pop (plain or tail call) from an empty stack.
            unf_nxt_s   = 1'b1;
            state_nxt_s = ST_ERR;
          end else if (call && ret) begin
            // Tail call: return the top and replace it in one cycle.
            ret_addr_nxt_s  = rdata_s;
            ret_valid_nxt_s = 1'b1;
            we_s            = 1'b1;
            waddr_s         = sp_m1_s;
          end else if (call && full_s) begin
            ovf_nxt_s = 1'b1;
`ifdef CTRL_PILA_WRAP_EN
            // Circular mode: overwrite the oldest slot, depth saturates.
            we_s     = 1'b1;
            sp_nxt_s = sp_p1_s;
`else
            state_nxt_s = ST_ERR;
`endif
          end else if (call) begin
            we_s        = 1'b1;
            sp_nxt_s    = sp_p1_s;
            depth_nxt_s = depth_r + (PW+1)'(1);
          end else if (ret) begin
            ret_addr_nxt_s  = rdata_s;
            ret_valid_nxt_s = 1'b1;
            sp_nxt_s        = sp_m1_s;
            depth_nxt_s     = depth_r - (PW+1)'(1);
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ERR: begin
          // Frozen: commands ignored until clr_err.
          state_nxt_s = ST_ERR;
        end
        default: begin
          state_nxt_s = ST_ERR;
        end
      endcase
    end
  end

  // Register all controller state and outputs; async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      sp_r        <= PW'(0);
      depth_r     <= (PW+1)'(0);
      ret_addr_r  <= AW'(0);
      ret_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sp_r        <= sp_nxt_s;
      depth_r     <= depth_nxt_s;
      ret_addr_r  <= ret_addr_nxt_s;
      ret_valid_r <= ret_valid_nxt_s;
      ovf_r       <= ovf_nxt_s;
      unf_r       <= unf_nxt_s;
    end
  end

  assign ret_addr  = ret_addr_r;
  assign ret_valid = ret_valid_r;
  assign depth     = depth_r;
  assign full      = full_s;
  assign empty     = empty_s;
  assign ovf       = ovf_r;
  assign unf       = unf_r;

endmodule

// File: tb/tb_ctrl_pila.sv
// tb_ctrl_pila: self-checking bench for ctrl_pila.
// Reference model is a queue-based stack with sticky flags; directed
// scenarios plus a randomized run are compared every cycle.
module tb_ctrl_pila;
  localparam int AW = 10;
  localparam int DEPTH = 8;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          call = 1'b0;
  logic          ret = 1'b0;
  logic          clr_err = 1'b0;
  logic [AW-1:0] pc_in = '0;
  logic [AW-1:0] ret_addr;
  logic          ret_valid;
  logic [PW:0]   depth;
  logic          full, empty, ovf, unf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [AW-1:0] q[$];
  logic [AW-1:0] m_ra;
  logic          m_rv, m_ovf, m_unf, m_err;

  ctrl_pila dut (
    .clk(clk), .reset(reset), .call(call), .ret(ret), .pc_in(pc_in),
    .clr_err(clr_err), .ret_addr(ret_addr), .ret_valid(ret_valid),
    .depth(depth), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_ra = '0; m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic r,
                            input logic [AW-1:0] pc, input logic clr);
    m_rv = 1'b0;
    if (clr) begin
      m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0;
    end else if (!m_err) begin
      if (r && q.size() == 0) begin
        m_unf = 1'b1; m_err = 1'b1;
      end else if (c && r) begin
        m_ra = q[q.size()-1];
        q[q.size()-1] = pc;
        m_rv = 1'b1;
      end else if (c && q.size() == DEPTH) begin
        m_ovf = 1'b1;
`ifdef CTRL_PILA_WRAP_EN
        void'(q.pop_front());
        q.push_back(pc);
`else
        m_err = 1'b1;
`endif
      end else if (c) begin
        q.push_back(pc);
      end else if (r) begin
        m_ra = q.pop_back();
        m_rv = 1'b1;
      end
    end
  endtask

  function automatic logic [18:0] exp_vec();
    return {m_ra, m_rv, 4'(q.size()), (q.size() == DEPTH), (q.size() == 0), m_ovf, m_unf};
  endfunction

  // Drive one clock's worth of inputs, advance model, settle past the edge.
  task automatic cycle(input logic c, input logic r,
                       input logic [AW-1:0] pc, input logic clr);
    call = c; ret = r; pc_in = pc; clr_err = clr;
    @(posedge clk);
    model_step(c, r, pc, clr);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({ret_addr, ret_valid, depth, full, empty, ovf, unf} !==
        {10'h000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got ra=%h rv=%b d=%0d f=%b e=%b o=%b u=%b",
               ret_addr, ret_valid, depth, full, empty, ovf, unf);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [AW-1:0] pcs [2];
    logic [AW-1:0] rets [2];
    pcs[0] = 10'h005; pcs[1] = 10'h01A;
    rets[0] = 10'h01A; rets[1] = 10'h005;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, pcs[i], 1'b0);
      checks++;
      if ({ret_addr, ret_valid, depth, full, empty, ovf, unf} !== exp_vec()) begin
        errors++;
        $display("FAIL basic_push: got %h exp %h",
                 {ret_addr, ret_valid, depth, full, empty, ovf, unf}, exp_vec());
      end
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 10'h000, 1'b0);
      checks++;
      if (ret_addr !== rets[i] || ret_valid !== 1'b1) begin
        errors++;
        $display("FAIL basic_pop: got ra=%h rv=%b exp ra=%h rv=1", ret_addr, ret_valid, rets[i]);
      end
    end
    cycle(1'b0, 1'b0, 10'h000, 1'b0);
    checks++;
    if (ret_valid !== 1'b0 || depth !== 4'd0 || empty !== 1'b1 || ret_addr !== 10'h005) begin
      errors++;
      $display("FAIL basic_end: got rv=%b d=%0d e=%b ra=%h exp rv=0 d=0 e=1 ra=005",
               ret_valid, depth, empty, ret_addr);
    end
  endtask

  task automatic test_overflow();
    int nrets;
    logic [AW-1:0] ev;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b0, AW'(i), 1'b0);
    end
    checks++;
    if (full !== 1'b1 || depth !== 4'd8 || {ret_addr, ret_valid, depth, full, empty, ovf, unf} !== exp_vec()) begin
      errors++;
      $display("FAIL ovf_fill: got f=%b d=%0d exp f=1 d=8", full, depth);
    end
    cycle(1'b1, 1'b0, 10'h009, 1'b0);
    checks++;
    if (ovf !== 1'b1 || depth !== 4'd8 || {ret_addr, ret_valid, depth, full, empty, ovf, unf} !== exp_vec()) begin
      errors++;
      $display("FAIL ovf_set: got o=%b d=%0d exp o=1 d=8", ovf, depth);
    end
    cycle(1'b0, 1'b1, 10'h000, 1'b0);
`ifdef CTRL_PILA_WRAP_EN
    // Still IDLE: the pop succeeds and returns the newest entry.
    checks++;
    if (ret_valid !== 1'b1 || ret_addr !== 10'h009) begin
      errors++;
      $display("FAIL wrap_idle_pop: got rv=%b ra=%h exp rv=1 ra=009", ret_valid, ret_addr);
    end
    nrets = 7; ev = 10'h008;
`else
    checks++;
    if (ret_valid !== 1'b0 || depth !== 4'd8) begin
      errors++;
      $display("FAIL err_ret_ignored: got rv=%b d=%0d exp rv=0 d=8", ret_valid, depth);
    end
    nrets = 8; ev = 10'h008;
`endif
    cycle(1'b0, 1'b0, 10'h000, 1'b1);
    checks++;
    if (ovf !== 1'b0 || {ret_addr, ret_valid, depth, full, empty, ovf, unf} !== exp_vec()) begin
      errors++;
      $display("FAIL ovf_clear: got o=%b exp o=0", ovf);
    end
    for (int i = 0; i < nrets; i++) begin
      cycle(1'b0, 1'b1, 10'h000, 1'b0);
      checks++;
      if (ret_addr !== ev || ret_valid !== 1'b1 ||
          {ret_addr, ret_valid, depth, full, empty, ovf, unf} !== exp_vec()) begin
        errors++;
        $display("FAIL ovf_drain: got ra=%h rv=%b exp ra=%h rv=1", ret_addr, ret_valid, ev);
      end
      ev = ev - 10'h001;
    end
  endtask

  task automatic test_underflow();
    logic [AW-1:0] prev;
    prev = ret_addr;
    cycle(1'b0, 1'b1, 10'h000, 1'b0);
    checks++;
    if (unf !== 1'b1 || ret_valid !== 1'b0 || ret_addr !== prev) begin
      errors++;
      $display("FAIL unf_set: got u=%b rv=%b ra=%h exp u=1 rv=0 ra=%h", unf, ret_valid, ret_addr, prev);
    end
    cycle(1'b1, 1'b0, 10'h3FF, 1'b0);
    checks++;
    if (depth !== 4'd0 || {ret_addr, ret_valid, depth, full, empty, ovf, unf} !== exp_vec()) begin
      errors++;
      $display("FAIL err_call_ignored: got d=%0d exp d=0", depth);
    end
    cycle(1'b0, 1'b0, 10'h000, 1'b1);
    checks++;
    if (unf !== 1'b0) begin
      errors++;
      $display("FAIL unf_clear: got u=%b exp u=0", unf);
    end
    cycle(1'b1, 1'b0, 10'h007, 1'b0);
    checks++;
    if (depth !== 4'd1) begin
      errors++;
      $display("FAIL idle_after_clear: got d=%0d exp d=1", depth);
    end
    cycle(1'b0, 1'b1, 10'h000, 1'b0);
  endtask

  task automatic test_tail_call();
    cycle(1'b1, 1'b0, 10'h011, 1'b0);
    cycle(1'b1, 1'b0, 10'h040, 1'b0);
    cycle(1'b1, 1'b1, 10'h099, 1'b0);
    checks++;
    if (ret_addr !== 10'h040 || ret_valid !== 1'b1 || depth !== 4'd2) begin
      errors++;
      $display("FAIL tail_call: got ra=%h rv=%b d=%0d exp ra=040 rv=1 d=2", ret_addr, ret_valid, depth);
    end
    cycle(1'b0, 1'b1, 10'h000, 1'b0);
    checks++;
    if (ret_addr !== 10'h099 || ret_valid !== 1'b1 || depth !== 4'd1) begin
      errors++;
      $display("FAIL tail_next_pop: got ra=%h rv=%b d=%0d exp ra=099 rv=1 d=1", ret_addr, ret_valid, depth);
    end
    cycle(1'b0, 1'b1, 10'h000, 1'b0);
    checks++;
    if (ret_addr !== 10'h011 || {ret_addr, ret_valid, depth, full, empty, ovf, unf} !== exp_vec()) begin
      errors++;
      $display("FAIL tail_last_pop: got ra=%h exp ra=011", ret_addr);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, AW'(10'h100 + i), 1'b0);
    end
    cycle(1'b0, 1'b1, 10'h000, 1'b0);
    checks++;
    if (depth !== 4'd3 || ret_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got d=%0d rv=%b exp d=3 rv=1", depth, ret_valid);
    end
    #3;
    call = 1'b0; ret = 1'b0; reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({ret_addr, ret_valid, depth, full, empty, ovf, unf} !==
        {10'h000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got ra=%h rv=%b d=%0d f=%b e=%b o=%b u=%b",
               ret_addr, ret_valid, depth, full, empty, ovf, unf);
    end
    #2;
    reset = 1'b1;
    cycle(1'b0, 1'b1, 10'h000, 1'b0);
    checks++;
    if (unf !== 1'b1 || ret_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_unf: got u=%b rv=%b exp u=1 rv=0", unf, ret_valid);
    end
    cycle(1'b0, 1'b0, 10'h000, 1'b1);
  endtask

  task automatic test_random();
    logic c, r, clr;
    for (int i = 0; i < 500; i++) begin
      c   = 1'($urandom_range(0, 1));
      r   = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 11) == 0);
      cycle(c, r, AW'($urandom), clr);
      checks++;
      if ({ret_addr, ret_valid, depth, full, empty, ovf, unf} !== exp_vec()) begin
        errors++;
        $display("FAIL random_step %0d: got %h exp %h", i,
                 {ret_addr, ret_valid, depth, full, empty, ovf, unf}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_tail_call();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
